instr_sequencer: RTL and testbench

- Control stage directly upstream of the dual-read register file.
- Fetches 32-bit instructions from a synchronous-read program ROM and drives the shared 16-bit opcode bus, the three 4-bit register addresses and the register write_enable.
- Handshakes with the RAM port for load/store instructions.
- Runs a multi-cycle FSM with one instruction in flight, and stops on HALT or end of program.

---
 rtl/instr_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_instr_sequencer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// Purpose: fetches instructions from a sync-read ROM and sequences register-file and RAM control.
// Latency: one instruction in flight; from FETCH to the next FETCH is 4 cycles for READ/NOP and 5 for ALU.
// Backpressure: RAM ops wait in MEM_WAIT with ram_req held for ram_done (no timeout); start is ignored while busy.
module instr_sequencer #(
    parameter int PC_WIDTH    = 8,
    parameter int INSTR_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    output logic [PC_WIDTH-1:0]    rom_addr,
    input  logic [INSTR_WIDTH-1:0] rom_data,
    output logic [15:0]            opcode,
    output logic [3:0]             addr_1,
    output logic [3:0]             addr_2,
    output logic [3:0]             addr_3,
    output logic                   write_enable,
    output logic                   ram_req,
    input  logic                   ram_done,
    output logic                   busy,
    output logic                   halted,
    output logic [PC_WIDTH-1:0]    pc
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_FETCH_WAIT,
        S_EXECUTE,
        S_MEM_WAIT,
        S_WRITEBACK,
        S_NEXT,
        S_HALTED
    } state_t;

    typedef enum logic [2:0] {
        C_NOP,
        C_ALU,
        C_READ,
        C_READ_RAM,
        C_WRITE_RAM,
        C_HALT
    } cls_t;

    localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

    state_t state, state_d;
    cls_t   cls_q, cls_d;

    logic [PC_WIDTH-1:0] pc_d;
    logic [PC_WIDTH-1:0] rom_addr_d;
    logic [15:0]         opcode_d;
    logic [3:0]          addr_1_d;
    logic [3:0]          addr_2_d;
    logic [3:0]          addr_3_d;
    logic                write_enable_d;
    logic                ram_req_d;
    logic                busy_d;
    logic                halted_d;

    // Reserved instruction bits carry no meaning for this stage.
    logic unused_rsvd;
    assign unused_rsvd = ^rom_data[15:12];

    // Classify an opcode; ALU is checked first since it is the only nibble-wide match.
    function automatic cls_t decode(input logic [15:0] op);
        if (op[15:12] == 4'b0001) return C_ALU;
        if (op[15:8] == 8'h22)    return C_READ;
        if (op[15:8] == 8'h92)    return C_READ_RAM;
        if (op[15:8] == 8'h91)    return C_WRITE_RAM;
        if (op[15:8] == 8'hFF)    return C_HALT;
        return C_NOP;
    endfunction

    // State and all registered outputs; reset clears everything immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            cls_q        <= C_NOP;
            pc           <= '0;
            rom_addr     <= '0;
            opcode       <= 16'h0000;
            addr_1       <= 4'h0;
            addr_2       <= 4'h0;
            addr_3       <= 4'h0;
            write_enable <= 1'b0;
            ram_req      <= 1'b0;
            busy         <= 1'b0;
            halted       <= 1'b0;
        end else begin
            state        <= state_d;
            cls_q        <= cls_d;
            pc           <= pc_d;
            rom_addr     <= rom_addr_d;
            opcode       <= opcode_d;
            addr_1       <= addr_1_d;
            addr_2       <= addr_2_d;
            addr_3       <= addr_3_d;
            write_enable <= write_enable_d;
            ram_req      <= ram_req_d;
            busy         <= busy_d;
            halted       <= halted_d;
        end
    end

    // Next-state selection; EXECUTE dispatches on the class latched with the instruction.
    always_comb begin
        state_d = state;
        unique case (state)
            S_IDLE: begin
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                state_d = S_FETCH_WAIT;
            end
            S_FETCH_WAIT: begin
                state_d = S_EXECUTE;
            end
            S_EXECUTE: begin
                unique case (cls_q)
                    C_ALU:                   state_d = S_WRITEBACK;
                    C_READ_RAM, C_WRITE_RAM: state_d = S_MEM_WAIT;
                    C_HALT:                  state_d = S_HALTED;
                    default:                 state_d = S_NEXT;
                endcase
            end
            S_MEM_WAIT: begin
                if (ram_done) begin
                    state_d = (cls_q == C_READ_RAM) ? S_WRITEBACK : S_NEXT;
                end
            end
            S_WRITEBACK: begin
                state_d = S_NEXT;
            end
            S_NEXT: begin
                // Running off the top of the address space ends the program.
                state_d = (&pc) ? S_HALTED : S_FETCH;
            end
            S_HALTED: begin
                if (start) state_d = S_FETCH;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Next values of the registered outputs, derived from the current and next state.
    always_comb begin
        pc_d       = pc;
        rom_addr_d = rom_addr;
        opcode_d   = 16'h0000;
        addr_1_d   = addr_1;
        addr_2_d   = addr_2;
        addr_3_d   = addr_3;
        cls_d      = cls_q;

        if ((state == S_IDLE || state == S_HALTED) && start) begin
            pc_d = '0;
        end else if (state == S_NEXT) begin
            // Wraps to zero naturally when pc is all-ones.
            pc_d = pc + PC_ONE;
        end

        // The ROM address only moves when a fetch is actually issued.
        if (state_d == S_FETCH) begin
            rom_addr_d = pc_d;
        end

        // Opcode is only visible while the instruction is being acted on.
        if (state == S_FETCH_WAIT) begin
            opcode_d = rom_data[31:16];
            addr_1_d = rom_data[11:8];
            addr_2_d = rom_data[7:4];
            addr_3_d = rom_data[3:0];
            cls_d    = decode(rom_data[31:16]);
        end else if (state_d == S_EXECUTE || state_d == S_MEM_WAIT ||
                     state_d == S_WRITEBACK) begin
            opcode_d = opcode;
        end

        // Write strobe and RAM request come from disjoint states, so they never overlap.
        write_enable_d = (state_d == S_WRITEBACK);
        ram_req_d      = (state_d == S_MEM_WAIT);
        busy_d         = (state_d != S_IDLE) && (state_d != S_HALTED);
        halted_d       = (state_d == S_HALTED);
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: ALU, RAM handshakes, pc wrap, start-while-busy, async reset.
// Outputs sampled on the falling edge; inputs driven on the falling edge.
// ROM models are synchronous-read arrays owned by the bench.
module tb_instr_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  rom_addr;
    logic [31:0] rom_data;
    logic [15:0] opcode;
    logic [3:0]  addr_1, addr_2, addr_3;
    logic        write_enable, ram_req, ram_done, busy, halted;
    logic [7:0]  pc;

    logic        start2;
    logic [1:0]  rom_addr2;
    logic [31:0] rom_data2;
    logic [15:0] opcode2;
    logic [3:0]  addr_1b, addr_2b, addr_3b;
    logic        write_enable2, ram_req2, busy2, halted2;
    logic [1:0]  pc2;

    logic [31:0] mem  [256];
    logic [31:0] mem2 [4];

    int n_assert = 0;
    int n_fail   = 0;
    int we_cnt   = 0;
    int overlap_cnt = 0;
    int we0;

    instr_sequencer #(.PC_WIDTH(8), .INSTR_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .opcode(opcode), .addr_1(addr_1), .addr_2(addr_2), .addr_3(addr_3),
        .write_enable(write_enable), .ram_req(ram_req), .ram_done(ram_done),
        .busy(busy), .halted(halted), .pc(pc)
    );

    instr_sequencer #(.PC_WIDTH(2), .INSTR_WIDTH(32)) dut2 (
        .clk(clk), .reset(reset), .start(start2),
        .rom_addr(rom_addr2), .rom_data(rom_data2),
        .opcode(opcode2), .addr_1(addr_1b), .addr_2(addr_2b), .addr_3(addr_3b),
        .write_enable(write_enable2), .ram_req(ram_req2), .ram_done(1'b0),
        .busy(busy2), .halted(halted2), .pc(pc2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous-read program ROMs.
    always @(posedge clk) begin
        rom_data  <= mem[rom_addr];
        rom_data2 <= mem2[rom_addr2];
    end

    // Running tallies of write strobes and of any strobe/request overlap.
    always @(negedge clk) begin
        if (write_enable === 1'b1) we_cnt++;
        if (write_enable === 1'b1 && ram_req === 1'b1) overlap_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; start2 = 1'b0; ram_done = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        for (int i = 0; i < 4; i++) mem2[i] = 32'h0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        cyc();

        // Reset state
        chk("rst_pc", pc, 0);
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_opcode", opcode, 0);
        chk("rst_addrs", {addr_1, addr_2, addr_3}, 0);
        chk("rst_we", write_enable, 0);
        chk("rst_req", ram_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_halted", halted, 0);

        // ALU then HALT
        mem[0] = 32'h1003_0123;
        mem[1] = 32'hFF00_0000;
        we0 = we_cnt;
        start = 1'b1; cyc(); start = 1'b0;           // FETCH pc0
        chk("t1_busy", busy, 1);
        chk("t1_rom_addr0", rom_addr, 0);
        chk("t1_fetch_opcode", opcode, 0);
        cyc();                                       // FETCH_WAIT
        chk("t1_fw_opcode", opcode, 0);
        cyc();                                       // EXECUTE
        chk("t1_ex_opcode", opcode, 16'h1003);
        chk("t1_ex_addrs", {addr_1, addr_2, addr_3}, 12'h123);
        chk("t1_ex_we", write_enable, 0);
        cyc();                                       // WRITEBACK
        chk("t1_wb_we", write_enable, 1);
        chk("t1_wb_opcode", opcode, 16'h1003);
        chk("t1_wb_addr3", addr_3, 3);
        cyc();                                       // NEXT
        chk("t1_next_we", write_enable, 0);
        chk("t1_next_opcode", opcode, 0);
        chk("t1_next_rom_addr", rom_addr, 0);
        cyc();                                       // FETCH pc1, 5 cycles after FETCH pc0
        chk("t1_fetch1_rom_addr", rom_addr, 1);
        chk("t1_fetch1_pc", pc, 1);
        cyc(); cyc();                                // EXECUTE HALT
        chk("t1_halt_opcode", opcode, 16'hFF00);
        chk("t1_halt_not_yet", halted, 0);
        cyc();                                       // HALTED
        chk("t1_halted", halted, 1);
        chk("t1_halted_busy", busy, 0);
        chk("t1_halted_opcode", opcode, 0);
        chk("t1_we_pulses", we_cnt - we0, 1);

        // READ_RAM (3-cycle wait) then WRITE_RAM (done in first wait cycle)
        mem[0] = 32'h9200_0005;
        mem[1] = 32'h9100_0007;
        mem[2] = 32'hFF00_0000;
        we0 = we_cnt;
        start = 1'b1; cyc(); start = 1'b0;           // FETCH pc0 from HALTED
        chk("t2_restart_busy", busy, 1);
        chk("t2_restart_halted", halted, 0);
        chk("t2_restart_pc", pc, 0);
        cyc(); cyc();                                // EXECUTE READ_RAM
        chk("t2_ex_opcode", opcode, 16'h9200);
        chk("t2_ex_req", ram_req, 0);
        ram_done = 1'b1; cyc(); ram_done = 1'b0;     // stray done in EXECUTE, now MEM_WAIT
        for (int k = 0; k < 3; k++) begin
            chk("t2_mw_req", ram_req, 1);
            chk("t2_mw_opcode", opcode, 16'h9200);
            chk("t2_mw_we", write_enable, 0);
            if (k < 2) cyc();
        end
        ram_done = 1'b1; cyc(); ram_done = 1'b0;     // WRITEBACK
        chk("t2_wb_req", ram_req, 0);
        chk("t2_wb_we", write_enable, 1);
        chk("t2_wb_addr3", addr_3, 5);
        chk("t2_wb_opcode", opcode, 16'h9200);
        cyc();                                       // NEXT
        chk("t2_next_we", write_enable, 0);
        cyc();                                       // FETCH pc1
        chk("t2_fetch1_pc", pc, 1);
        cyc(); cyc();                                // EXECUTE WRITE_RAM
        chk("t2_wr_ex_opcode", opcode, 16'h9100);
        chk("t2_wr_ex_req", ram_req, 0);
        cyc();                                       // MEM_WAIT first cycle
        chk("t2_wr_mw_req", ram_req, 1);
        chk("t2_wr_mw_addr3", addr_3, 7);
        chk("t2_wr_mw_we", write_enable, 0);
        ram_done = 1'b1; cyc(); ram_done = 1'b0;     // NEXT
        chk("t2_wr_next_req", ram_req, 0);
        chk("t2_wr_next_we", write_enable, 0);
        chk("t2_wr_next_busy", busy, 1);
        cyc();                                       // FETCH pc2
        chk("t2_fetch2_rom_addr", rom_addr, 2);
        cyc(); cyc(); cyc();                         // HALTED
        chk("t2_halted", halted, 1);
        chk("t2_we_pulses", we_cnt - we0, 1);

        // 2-bit pc with four NOPs: wraps into HALTED
        start2 = 1'b1; cyc(); start2 = 1'b0;
        chk("t3_start_pc", pc2, 0);
        chk("t3_start_busy", busy2, 1);
        for (int i = 1; i < 4; i++) begin
            repeat (4) cyc();
            chk("t3_walk_pc", pc2, i);
            chk("t3_walk_rom_addr", rom_addr2, i);
        end
        repeat (3) cyc();                            // NEXT of pc3
        chk("t3_last_busy", busy2, 1);
        chk("t3_last_halted", halted2, 0);
        cyc();
        chk("t3_wrap_halted", halted2, 1);
        chk("t3_wrap_busy", busy2, 0);
        chk("t3_wrap_pc", pc2, 0);
        chk("t3_no_fetch", rom_addr2, 3);
        start2 = 1'b1; cyc(); start2 = 1'b0;
        chk("t3_rerun_busy", busy2, 1);
        chk("t3_rerun_rom_addr", rom_addr2, 0);
        repeat (4) cyc();
        chk("t3_rerun_pc", pc2, 1);

        // start while busy, then reset in MEM_WAIT
        mem[0] = 32'h0000_0000;
        mem[1] = 32'h9200_0001;
        start = 1'b1; cyc(); start = 1'b0;           // FETCH pc0
        cyc(); cyc();                                // EXECUTE NOP
        start = 1'b1; cyc(); start = 1'b0;           // NEXT, start ignored
        cyc();                                       // FETCH pc1
        chk("t4_busy_start_pc", pc, 1);
        chk("t4_busy_start_rom_addr", rom_addr, 1);
        cyc(); cyc(); cyc();                         // MEM_WAIT
        chk("t4_mw_req", ram_req, 1);
        #2 reset = 1'b1;
        #1;
        chk("t4_rst_req", ram_req, 0);
        chk("t4_rst_we", write_enable, 0);
        chk("t4_rst_busy", busy, 0);
        chk("t4_rst_opcode", opcode, 0);
        chk("t4_rst_pc", pc, 0);
        @(negedge clk);
        reset = 1'b0;
        cyc(); cyc();
        chk("t4_idle_busy", busy, 0);
        chk("t4_idle_halted", halted, 0);
        chk("t4_idle_rom_addr", rom_addr, 0);

        chk("we_req_overlap", overlap_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
